// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline registers: occupancy encoding,
// stage payload structs (use $bits(<struct>) as DATA_W) and a small helper.
package pipe_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } mem_wb_t;

  // Number of held entries given the two valid bits.
  function automatic occ_t occ_count(input logic head_v, input logic skid_v);
    return occ_t'({1'b0, head_v} + {1'b0, skid_v});
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit, error flag and payload.
// clear beats load beats pop for the valid bit; payload and err only change
// on load, so they hold stale contents while the entry is invalid.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_err,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // Next-state for the entry: kill, fill, drain or hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (load) begin
      data_d = d_data;
      err_d  = d_err;
    end
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Entry state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign err   = err_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with optional 2-entry skid buffer, flush,
// sticky error flag and saturating stall counter.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high (in_fire / out_fire). A producer holds valid and its payload stable
// until the transfer; ready may be asserted without valid. With SKID=1,
// in_ready is !skid_valid, a flop output, so out_ready never reaches in_ready
// combinationally. With SKID=0, in_ready = !head_valid || out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [1:0]        occupancy,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              head_valid, head_err;
  logic [DATA_W-1:0] head_data;
  logic              skid_valid, skid_err;
  logic [DATA_W-1:0] skid_data;

  logic              head_load, head_pop, skid_load, skid_pop;
  logic [DATA_W-1:0] head_d_data;
  logic              head_d_err;

  logic              in_fire, out_fire;

  logic              err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_ready = (SKID != 0) ? !skid_valid : (!head_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = head_valid && out_ready;

  // Steering: decide which entry loads, from where, and which drains.
  always_comb begin
    head_load   = 1'b0;
    head_pop    = 1'b0;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    head_d_data = in_data;
    head_d_err  = in_err;
    if (SKID != 0) begin
      if (skid_valid) begin
        // Skid full: in_ready is low, so only the skid->head move can happen.
        if (out_fire) begin
          head_load   = 1'b1;
          skid_pop    = 1'b1;
          head_d_data = skid_data;
          head_d_err  = skid_err;
        end
      end else if (!head_valid || out_fire) begin
        // Head free (or leaving this cycle): input goes straight to head.
        head_load = in_fire;
        head_pop  = out_fire && !in_fire;
      end else begin
        // Head stuck: park the input in the skid entry.
        skid_load = in_fire;
      end
    end else begin
      head_load = in_fire;
      head_pop  = out_fire && !in_fire;
    end
  end

  pipe_entry_reg #(.DATA_W(DATA_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .load   (head_load),
    .pop    (head_pop),
    .clear  (flush),
    .d_data (head_d_data),
    .d_err  (head_d_err),
    .valid  (head_valid),
    .data   (head_data),
    .err    (head_err)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .pop    (skid_pop),
        .clear  (flush),
        .d_data (in_data),
        .d_err  (in_err),
        .valid  (skid_valid),
        .data   (skid_data),
        .err    (skid_err)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_err   = 1'b0;
    end
  endgenerate

  // Sticky error and saturating stall counter next-state; flush wins.
  always_comb begin
    err_sticky_d = err_sticky_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush) begin
      err_sticky_d = 1'b0;
      stall_cnt_d  = '0;
    end else begin
      if (in_fire && in_err) begin
        err_sticky_d = 1'b1;
      end
      if (head_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign out_valid  = head_valid;
  assign out_data   = head_data;
  assign out_err    = head_err;
  assign occupancy  = occ_count(head_valid, skid_valid);
  assign err_sticky = err_sticky_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: main SKID=1 instance plus a CNT_W=3
// instance and a SKID=0 instance sharing the same inputs.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_err, flush, out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid, out_err, err_sticky;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          c3_in_ready, c3_out_valid, c3_out_err, c3_err_sticky;
  logic [DW-1:0] c3_out_data;
  logic [1:0]    c3_occupancy;
  logic [2:0]    c3_stall_cnt;

  logic          s0_in_ready, s0_out_valid, s0_out_err, s0_err_sticky;
  logic [DW-1:0] s0_out_data;
  logic [1:0]    s0_occupancy;
  logic [15:0]   s0_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_err(in_err), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .occupancy(occupancy), .err_sticky(err_sticky), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c3_in_ready),
    .in_data(in_data), .in_err(in_err), .flush(flush), .out_valid(c3_out_valid),
    .out_ready(out_ready), .out_data(c3_out_data), .out_err(c3_out_err),
    .occupancy(c3_occupancy), .err_sticky(c3_err_sticky), .stall_cnt(c3_stall_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(16)) dut_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s0_in_ready),
    .in_data(in_data), .in_err(in_err), .flush(flush), .out_valid(s0_out_valid),
    .out_ready(out_ready), .out_data(s0_out_data), .out_err(s0_out_err),
    .occupancy(s0_occupancy), .err_sticky(s0_err_sticky), .stall_cnt(s0_stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_err    = e;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Scoreboard on the main instance: outputs leaving must match accepted
  // inputs in order; flush drops everything held plus this cycle's input.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_extra", {31'd0, out_err, out_data}, 64'hDEAD);
        else chk("sb_data", {31'd0, out_err, out_data}, {31'd0, exp_q.pop_front()});
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_err, in_data});
    end
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    // Reset values
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_stall", stall_cnt, 0);
    tick();
    rst = 1'b0;

    // Stream 0x1..0x10 with downstream always ready
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
      tick();
      chk("strm_valid", out_valid, 1);
      chk("strm_data", out_data, i);
      chk("strm_occ", occupancy, 1);
      chk("s0_valid", s0_out_valid, 1);
      chk("s0_data", s0_out_data, i);
    end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("strm_drain_occ", occupancy, 0);
    chk("strm_stall", stall_cnt, 0);
    chk("s0_drain", s0_occupancy, 0);

    // Backpressure: A, B held, C waits upstream; 5 cycles of out_ready=0
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_head_a", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    tick();
    chk("bp_ready_lo", in_ready, 0);
    drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("bp_occ_full", occupancy, 2);
    chk("bp_ready_hold", in_ready, 0);
    chk("bp_head_hold", out_data, 32'hA);
    chk("bp_stall4", stall_cnt, 4);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b", out_data, 32'hB);
    chk("bp_rel_occ", occupancy, 1);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_rel_c", out_data, 32'hC);
    tick();
    chk("bp_empty", occupancy, 0);
    chk("bp_stall_keep", stall_cnt, 4);

    // Flush with two entries held and input offered
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fl_pre_occ", occupancy, 2);
    drive(1'b1, 32'h23, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_stall", stall_cnt, 0);
    chk("fl_ready", in_ready, 1);
    // Flush while the input actually fires: that beat is discarded
    drive(1'b1, 32'h24, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h25, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("fl_fire_occ", occupancy, 0);
    tick();
    tick();
    chk("fl_nothing", out_valid, 0);

    // Error flag travels with its payload; sticky until flush
    drive(1'b1, 32'h5, 1'b1, 1'b1, 1'b0);
    tick();
    chk("err_data5", out_data, 32'h5);
    chk("err_flag5", out_err, 1);
    chk("err_sticky_set", err_sticky, 1);
    drive(1'b1, 32'h6, 1'b0, 1'b1, 1'b0);
    tick();
    chk("err_data6", out_data, 32'h6);
    chk("err_flag6", out_err, 0);
    chk("err_sticky_hold", err_sticky, 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("err_sticky_clr", err_sticky, 0);
    // Flush together with an erroneous input: sticky stays clear
    drive(1'b1, 32'h7, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("err_fl_sticky", err_sticky, 0);
    chk("err_fl_occ", occupancy, 0);

    // Stall counter saturation (CNT_W=3) vs 16-bit count
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_c3", c3_stall_cnt, 7);
    chk("sat_main", stall_cnt, 10);
    chk("sat_c3_head", c3_out_data, 32'h8);

    // Async reset with two entries held
    drive(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid_occ2", occupancy, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_stall", stall_cnt, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", out_valid, 0);
    chk("sb_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
